// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode 7-segment display.
// Double-buffered display data, swapped only at frame boundaries.
module seg_scan_ctrl #(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int BLANK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  input  logic [NDIG-1:0]   load_mask,
  output logic [3:0]        nib,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] CLAST = CW'(DIV - 1);
  localparam logic [IW-1:0] ILAST = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] act_q, act_d;
  logic [NDIG-1:0]   amsk_q, amsk_d;
  logic [4*NDIG-1:0] shd_q;
  logic [NDIG-1:0]   smsk_q;
  logic              pend_q, pend_d;
  logic [NDIG-1:0]   an_d;
  logic [3:0]        nib_d;
  logic              fd_d;

  logic last_cnt;
  logic bound;
  logic copy;
  logic xfer;

  assign last_cnt = (cnt_q == CLAST);
  assign bound    = (state_q != S_IDLE) && last_cnt
                 && (idx_q == ILAST);
  assign copy     = pend_q && (bound || state_q == S_IDLE);
  assign xfer     = load_valid && !pend_q;

  assign load_ready = ~pend_q;

  always_comb begin
    state_d = S_IDLE;
    cnt_d   = '0;
    idx_d   = '0;
    act_d   = act_q;
    amsk_d  = amsk_q;
    pend_d  = pend_q;

    if (copy) begin
      act_d  = shd_q;
      amsk_d = smsk_q;
      pend_d = 1'b0;
    end
    if (xfer) pend_d = 1'b1;

    if (en) begin
      if (state_q != S_IDLE) begin
        cnt_d = last_cnt ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (last_cnt)
          idx_d = (idx_q == ILAST) ? '0 : idx_q + IW'(1);
      end
      state_d = (cnt_d < CW'(BLANK)) ? S_BLANK : S_SHOW;
    end
  end

  // Outputs are computed from next-state values so the registered
  // outputs line up with the registered state/counters.
  always_comb begin
    an_d  = '1;
    nib_d = '0;
    fd_d  = 1'b0;
    if (state_d != S_IDLE) begin
      nib_d = act_d[{idx_d, 2'b00} +: 4];
      fd_d  = (idx_d == ILAST) && (cnt_d == CLAST);
    end
    if (state_d == S_SHOW)
      an_d[idx_d] = ~amsk_d[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      act_q      <= '0;
      amsk_q     <= '0;
      shd_q      <= '0;
      smsk_q     <= '0;
      pend_q     <= 1'b0;
      an         <= '1;
      nib        <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      amsk_q     <= amsk_d;
      pend_q     <= pend_d;
      an         <= an_d;
      nib        <= nib_d;
      frame_done <= fd_d;
      if (xfer) begin
        shd_q  <= load_data;
        smsk_q <= load_mask;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NDIG=4, DIV=4, BLANK=1).
// Per-cycle vector table plus hand sequences for enable/reset cases.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        lv;
  logic        rdy;
  logic [15:0] ld;
  logic [3:0]  lm;
  logic [3:0]  nib;
  logic [3:0]  an;
  logic        fd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        en;
    logic        lv;
    logic [15:0] ld;
    logic [3:0]  lm;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        fd;
    logic        rdy;
  } vec_t;

  vec_t tv [0:127];
  int   n = 0;

  seg_scan_ctrl #(
    .NDIG (4),
    .DIV  (4),
    .BLANK(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load_valid(lv),
    .load_ready(rdy),
    .load_data (ld),
    .load_mask (lm),
    .nib       (nib),
    .an        (an),
    .frame_done(fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] ea,
                     input logic [3:0] enb, input logic ef,
                     input logic er);
    total++;
    if (an !== ea || nib !== enb || fd !== ef || rdy !== er) begin
      bad++;
      $display("FAIL %s: got an=%h nib=%h fd=%b rdy=%b want an=%h nib=%h fd=%b rdy=%b",
               nm, an, nib, fd, rdy, ea, enb, ef, er);
    end
  endtask

  task automatic add(input logic e, input logic v,
                     input logic [15:0] d, input logic [3:0] m,
                     input logic [3:0] ea, input logic [3:0] enb,
                     input logic ef, input logic er);
    tv[n].en  = e;
    tv[n].lv  = v;
    tv[n].ld  = d;
    tv[n].lm  = m;
    tv[n].an  = ea;
    tv[n].nib = enb;
    tv[n].fd  = ef;
    tv[n].rdy = er;
    n++;
  endtask

  // One full 16-cycle frame of a 4-digit, 4-cycle-slot, 1-blank scan.
  task automatic add_frame(input logic [15:0] d, input logic [3:0] m,
                           input logic er);
    for (int p = 0; p < 16; p++) begin
      int          di;
      int          c;
      logic [3:0]  ea;
      di = p / 4;
      c  = p % 4;
      ea = 4'hF;
      if (c != 0 && m[di]) ea[di] = 1'b0;
      add(1'b1, 1'b0, 16'h0, 4'h0, ea, d[di*4 +: 4], p == 15, er);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    lv    = 1'b0;
    ld    = 16'h0;
    lm    = 4'h0;

    add(1'b0, 1'b1, 16'h4321, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 4'h0, 4'hF, 4'h0, 1'b0, 1'b1);
    add_frame(16'h4321, 4'hF, 1'b1);
    add_frame(16'h4321, 4'hF, 1'b0);
    tv[18].rdy = 1'b1;
    tv[19].lv = 1'b1; tv[19].ld = 16'hAAAA; tv[19].lm = 4'h5;
    tv[20].lv = 1'b1; tv[20].ld = 16'hBBBB; tv[20].lm = 4'hF;
    add_frame(16'hAAAA, 4'h5, 1'b1);
    add_frame(16'hAAAA, 4'h5, 1'b0);
    tv[50].lv = 1'b1; tv[50].ld = 16'h5555; tv[50].lm = 4'hF;
    add_frame(16'h5555, 4'hF, 1'b1);

    for (int i = 0; i < 3; i++) begin
      lv = ~lv;
      ld = 16'h1234 + 16'(i);
      lm = 4'hF;
      step();
      chk("reset_hold", 4'hF, 4'h0, 1'b0, 1'b1);
    end
    en    = 1'b0;
    lv    = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < n; i++) begin
      en = tv[i].en;
      lv = tv[i].lv;
      ld = tv[i].ld;
      lm = tv[i].lm;
      step();
      chk($sformatf("vec%0d", i), tv[i].an, tv[i].nib, tv[i].fd,
          tv[i].rdy);
    end

    en = 1'b1; lv = 1'b1; ld = 16'h9999; lm = 4'hF;
    step();
    chk("en_load", 4'hF, 4'h5, 1'b0, 1'b0);
    lv = 1'b0;
    repeat (8) step();
    chk("en_idx2", 4'hF, 4'h5, 1'b0, 1'b0);
    step();
    chk("en_idx2_show", 4'hB, 4'h5, 1'b0, 1'b0);
    en = 1'b0;
    step();
    chk("en_drop", 4'hF, 4'h0, 1'b0, 1'b0);
    step();
    chk("idle_copy", 4'hF, 4'h0, 1'b0, 1'b1);
    en = 1'b1;
    step();
    chk("restart_blank", 4'hF, 4'h9, 1'b0, 1'b1);
    step();
    chk("restart_show", 4'hE, 4'h9, 1'b0, 1'b1);

    lv = 1'b1; ld = 16'h7777; lm = 4'hF;
    step();
    chk("load7", 4'hE, 4'h9, 1'b0, 1'b0);
    lv = 1'b0;
    repeat (13) step();
    chk("bound_fd", 4'h7, 4'h9, 1'b1, 1'b0);
    en = 1'b0;
    step();
    chk("bound_en_fall", 4'hF, 4'h0, 1'b0, 1'b1);
    en = 1'b1;
    step();
    chk("bound_new", 4'hF, 4'h7, 1'b0, 1'b1);
    step();
    chk("bound_new_show", 4'hE, 4'h7, 1'b0, 1'b1);

    lv = 1'b1; ld = 16'h1234; lm = 4'hF;
    step();
    chk("pre_rst", 4'hE, 4'h7, 1'b0, 1'b0);
    lv = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 4'hF, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      lv = ~lv;
      step();
      chk("rst_hold2", 4'hF, 4'h0, 1'b0, 1'b1);
    end
    en = 1'b0; lv = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 4'hF, 4'h0, 1'b0, 1'b1);
    step();
    en = 1'b1;
    step();
    chk("post_rst_blank", 4'hF, 4'h0, 1'b0, 1'b1);
    step();
    chk("post_rst_dark", 4'hF, 4'h0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
